// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: boot hold, load-use stall, jump flush and memory freeze,
// with saturating stall/flush performance counters. rst_n is an active-high async reset.
module pipe_hazard_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_use_rs1,
   input  logic        id_use_rs2,
   input  logic [4:0]  ex_rd,
   input  logic        ex_memread,
   input  logic        jump_ex,
   input  logic        mem_busy,
   output logic        pc_en,
   output logic        ifid_en,
   output logic        idex_en,
   output logic        ifid_flush,
   output logic        idex_flush,
   output logic        ready,
   output logic [15:0] stall_cnt,
   output logic [15:0] flush_cnt
);

   localparam logic [1:0] BOOT   = 2'd0;
   localparam logic [1:0] RUN    = 2'd1;
   localparam logic [1:0] FREEZE = 2'd2;

   logic [1:0]  r_state;
   logic [1:0]  w_state_nxt;
   logic [1:0]  r_boot_cnt;
   logic [15:0] r_stall_cnt;
   logic [15:0] r_flush_cnt;
   logic        w_load_use;
   logic        w_jump_flush;
   logic        w_stall;

   // x0 is hardwired zero, so a load targeting it can never create a dependency.
   assign w_load_use = ex_memread && (ex_rd != 5'd0) &&
                       ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                        (id_use_rs2 && (id_rs2 == ex_rd)));

   always_comb begin
      // NOTE: every output gets a default first, so no path leaves one unassigned (no latch).
      pc_en        = 1'b1;
      ifid_en      = 1'b1;
      idex_en      = 1'b1;
      ifid_flush   = 1'b0;
      idex_flush   = 1'b0;
      ready        = 1'b1;
      w_jump_flush = 1'b0;
      w_state_nxt  = r_state;
      case (r_state)
         RUN: begin
            if (mem_busy) begin
               pc_en       = 1'b0;
               ifid_en     = 1'b0;
               idex_en     = 1'b0;
               w_state_nxt = FREEZE;
            end else if (jump_ex) begin
               ifid_flush   = 1'b1;
               idex_flush   = 1'b1;
               w_jump_flush = 1'b1;
            end else if (w_load_use) begin
               pc_en      = 1'b0;
               ifid_en    = 1'b0;
               idex_flush = 1'b1;
            end
         end
         FREEZE: begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            idex_en = 1'b0;
            if (!mem_busy) w_state_nxt = RUN;
         end
         default: begin
            // BOOT, and any unreachable encoding falls back into it.
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            ready      = 1'b0;
            w_state_nxt = (r_state == BOOT && r_boot_cnt == 2'd3) ? RUN : BOOT;
         end
      endcase
   end

   assign w_stall = !pc_en && ((r_state == RUN) || (r_state == FREEZE));

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         r_state     <= BOOT;
         r_boot_cnt  <= 2'd0;
         r_stall_cnt <= 16'd0;
         r_flush_cnt <= 16'd0;
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge values.
         r_state    <= w_state_nxt;
         r_boot_cnt <= (r_state == BOOT) ? r_boot_cnt + 2'd1 : 2'd0;
         if (w_stall && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
         if (w_jump_flush && (r_flush_cnt != 16'hFFFF)) r_flush_cnt <= r_flush_cnt + 16'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: pipeline clock, all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have ports id_rs1, id_rs2, input, 5 bits each: source register indices of the instruction in ID.
REQ-004 SHALL have ports id_use_rs1, id_use_rs2, input, 1 bit each: the ID instruction reads rs1 / rs2.
REQ-005 SHALL have port ex_rd, input, 5 bits: destination register of the instruction in EX.
REQ-006 SHALL have port ex_memread, input, 1 bit: the EX instruction is a load.
REQ-007 SHALL have port jump_ex, input, 1 bit: taken branch or jump resolved in EX.
REQ-008 SHALL have port mem_busy, input, 1 bit: data memory not ready, so the pipeline must hold.
REQ-009 SHALL have ports pc_en, ifid_en, idex_en, output, 1 bit each: stage register write enables.
REQ-010 SHALL have ports ifid_flush, idex_flush, output, 1 bit each: load a NOP (32'h00000033) into IF/ID / ID/EX.
REQ-011 SHALL have port ready, output, 1 bit: high when the boot hold is complete.
REQ-012 SHALL have ports stall_cnt, flush_cnt, output, 16 bits each: saturating performance counters.

Function
REQ-013 SHALL implement the states BOOT, RUN and FREEZE, held in a registered state variable.
REQ-014 BOOT SHALL hold for exactly 4 clk cycles after reset release, tracked by a 2-bit counter 0..3; at count 3 the next state SHALL be RUN.
REQ-015 In BOOT the outputs SHALL be: pc_en=0, ifid_en=0, idex_en=1, ifid_flush=1, idex_flush=1, ready=0.
REQ-016 ready SHALL be 1 in RUN and in FREEZE.
REQ-017 RUN defaults SHALL be: pc_en=ifid_en=idex_en=1, both flushes 0.
REQ-018 Load-use hazard: ex_memread=1, ex_rd!=0, and (id_use_rs1 and id_rs1==ex_rd) or (id_use_rs2 and id_rs2==ex_rd).
REQ-019 On a load-use hazard in RUN, the same cycle (combinational) SHALL give pc_en=0, ifid_en=0, idex_flush=1; the result is one bubble with no state change.
REQ-020 On jump_ex=1 in RUN, the same cycle SHALL give ifid_flush=1, idex_flush=1, pc_en=1.
REQ-021 Priority in RUN SHALL be: mem_busy > jump_ex > load-use; with jump and load-use together, the jump is taken and there is no stall.
REQ-022 On mem_busy=1 in RUN, the same cycle SHALL freeze the pipeline: pc_en=ifid_en=idex_en=0, all flushes 0; next state SHALL be FREEZE.
REQ-023 FREEZE SHALL apply the freeze outputs every cycle regardless of other inputs; jump_ex and hazards are ignored because EX is held and they re-present in RUN.
REQ-024 FREEZE SHALL go to RUN on the first edge where mem_busy=0 is sampled; this gives exactly one recovery freeze cycle after mem_busy falls.
REQ-025 stall_cnt SHALL increment on each edge where pc_en=0 and the state is RUN or FREEZE; it is not counted in BOOT.
REQ-026 flush_cnt SHALL increment on each edge where a jump flush (REQ-020) is applied.
REQ-027 Both counters SHALL saturate at 16'hFFFF and never wrap.
REQ-028 No registered output SHALL depend on X; the zero register (ex_rd=0) SHALL never produce a stall.

Reset
REQ-029 rst_n=1 SHALL asynchronously force: state BOOT, boot count 0, stall_cnt=0, flush_cnt=0.
REQ-030 While rst_n=1, the outputs SHALL be the BOOT values.
REQ-031 Reset asserted mid-FREEZE or mid-stall SHALL abandon the operation immediately and restart BOOT after release.

Verification
REQ-032 Release reset, other inputs 0 -> ready=0 and pc_en=0 for 4 cycles, then ready=1, pc_en=1, stall_cnt=0.
REQ-033 In RUN, drive ex_memread=1, ex_rd=5, id_rs2=5, id_use_rs2=1 for one cycle -> pc_en=0, ifid_en=0, idex_flush=1 that cycle; stall_cnt=1.
REQ-034 Same stimulus as REQ-033 with ex_rd=0 -> no stall; also drive jump_ex=1 together with a valid load-use -> flushes=1, pc_en=1, flush_cnt+1, stall_cnt unchanged.
REQ-035 mem_busy=1 for 3 cycles with jump_ex=1 -> 4 freeze cycles total, no flush asserted, stall_cnt+4, then RUN.
REQ-036 Preload stall_cnt at 16'hFFFE, then hold 3 stall cycles -> counter reads 16'hFFFF and stays there.
REQ-037 Assert rst_n during FREEZE -> outputs take BOOT values immediately and both counters read 0.
